// File: rtl/gpu_data_mem_arbiter_pkg.sv
// ============================================================================
// Module  : gpu_mem_pkg
// Purpose : Shared types and constants for the GPU memory-side arbiters:
//           the arbitration FSM state encoding and the operation codes
//           latched with each granted request.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package gpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_arb_state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/gpu_data_mem_arbiter_if.sv
// ============================================================================
// Module  : gpu_data_mem_arbiter_if
// Purpose : Bundle of the per-channel read/write request channels between the
//           GPU data-memory ports (master) and the memory arbiter (slave).
// Ports   : ch_read_valid/address   -> read request, held until ready
//           ch_read_ready/data      <- 1-cycle ready pulse, held read data
//           ch_write_valid/address/data -> write request, held until ready
//           ch_write_ready          <- 1-cycle commit pulse
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface gpu_data_mem_arbiter_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8
);

  logic [NUM_CHANNELS-1:0]                ch_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] ch_read_address;
  logic [NUM_CHANNELS-1:0]                ch_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_read_data;
  logic [NUM_CHANNELS-1:0]                ch_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] ch_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_write_data;
  logic [NUM_CHANNELS-1:0]                ch_write_ready;

  modport master (
    output ch_read_valid, ch_read_address,
    input  ch_read_ready, ch_read_data,
    output ch_write_valid, ch_write_address, ch_write_data,
    input  ch_write_ready
  );

  modport slave (
    input  ch_read_valid, ch_read_address,
    output ch_read_ready, ch_read_data,
    input  ch_write_valid, ch_write_address, ch_write_data,
    output ch_write_ready
  );

endinterface

`default_nettype wire

// File: rtl/gpu_data_mem_arbiter_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Purpose : Purely combinational round-robin picker. Returns the first
//           requesting index at or after ptr (wrapping modulo N).
// Ports   : req     in  N       request vector
//           ptr     in  log2(N) search start index
//           grant   out log2(N) selected index (0 when nothing requests)
//           any_req out 1       at least one request present
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 any_req
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W:0] cand;

  // Walk offsets from the farthest back to 0 so the closest requester to
  // ptr is the last one written and therefore wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(N)) begin
        cand = cand - (IDX_W + 1)'(N);
      end
      if (req[cand[IDX_W-1:0]]) begin
        grant   = cand[IDX_W-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpu_data_mem_arbiter.sv
// ============================================================================
// Module  : gpu_data_mem_arbiter
// Purpose : Serves NUM_CHANNELS read/write request channels onto one
//           synchronous single-port SRAM with 1-cycle read latency.
//           One access every 3 cycles: IDLE (grant) -> ACCESS (sram_en high)
//           -> RESP (read data arrives) -> ready pulse visible back in IDLE.
// Ports   : clk, reset        clock, asynchronous active-high reset
//           ch                slave side of the request channel bundle
//           sram_en/we/addr/wdata  registered SRAM command
//           sram_rdata        SRAM read data, valid the cycle after a read
//           busy              FSM not in IDLE
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gpu_data_mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  gpu_data_mem_arbiter_if.slave ch,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_BITS-1:0]  sram_addr,
  output logic [DATA_BITS-1:0]  sram_wdata,
  input  logic [DATA_BITS-1:0]  sram_rdata,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NUM_CHANNELS);

  mem_arb_state_t state, state_next;

  logic [NUM_CHANNELS-1:0] rd_drop, wr_drop;
  logic [NUM_CHANNELS-1:0] rd_req, wr_req, req;
  logic [IDX_W-1:0]        arb_grant, cur_grant, rr_ptr;
  logic                    any_req, cur_op;
  logic                    launch, end_access, finish, launch_op;
  logic [NUM_CHANNELS-1:0] read_ready_q, write_ready_q;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data_q;

  // Masks are kept per operation so a channel presenting read and write
  // together can have its read served after the write has been acknowledged
  // while the write's lingering valid stays blocked.
  assign rd_req = ch.ch_read_valid  & ~rd_drop;
  assign wr_req = ch.ch_write_valid & ~wr_drop;
  assign req    = rd_req | wr_req;

  rr_arbiter #(.N(NUM_CHANNELS)) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / strobe decode; writes take priority over reads on one channel.
  always_comb begin
    launch     = (state == IDLE) && any_req;
    end_access = (state == ACCESS);
    finish     = (state == RESP);
    launch_op  = wr_req[arb_grant] ? OP_WRITE : OP_READ;
  end

  // Datapath and registered outputs. sram_addr/sram_wdata double as the
  // latched request address/data; they hold until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_grant     <= '0;
      cur_op        <= OP_READ;
      rr_ptr        <= '0;
      rd_drop       <= '0;
      wr_drop       <= '0;
      sram_en       <= 1'b0;
      sram_we       <= 1'b0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      read_ready_q  <= '0;
      write_ready_q <= '0;
      read_data_q   <= '0;
    end else begin
      read_ready_q  <= '0;
      write_ready_q <= '0;
      // A mask bit clears once the channel's valid is seen low.
      rd_drop <= rd_drop & ch.ch_read_valid;
      wr_drop <= wr_drop & ch.ch_write_valid;

      if (launch) begin
        cur_grant  <= arb_grant;
        cur_op     <= launch_op;
        sram_en    <= 1'b1;
        sram_we    <= launch_op;
        sram_addr  <= (launch_op == OP_WRITE) ? ch.ch_write_address[arb_grant]
                                              : ch.ch_read_address[arb_grant];
        sram_wdata <= ch.ch_write_data[arb_grant];
        rr_ptr     <= (arb_grant == IDX_W'(NUM_CHANNELS - 1)) ? '0
                                                              : arb_grant + 1'b1;
      end

      if (end_access) begin
        sram_en <= 1'b0;
        sram_we <= 1'b0;
      end

      if (finish) begin
        if (cur_op == OP_WRITE) begin
          write_ready_q[cur_grant] <= 1'b1;
          wr_drop[cur_grant]       <= 1'b1;
        end else begin
          read_ready_q[cur_grant]  <= 1'b1;
          rd_drop[cur_grant]       <= 1'b1;
          read_data_q[cur_grant]   <= sram_rdata;
        end
      end
    end
  end

  assign ch.ch_read_ready  = read_ready_q;
  assign ch.ch_write_ready = write_ready_q;
  assign ch.ch_read_data   = read_data_q;
  assign busy              = (state != IDLE);

  // A granted request must stay valid until its ready pulse.
  granted_valid_held : assert property (
    @(posedge clk) disable iff (reset)
    (state != IDLE) |-> ((cur_op == OP_WRITE) ? ch.ch_write_valid[cur_grant]
                                              : ch.ch_read_valid[cur_grant])
  );

endmodule

`default_nettype wire

// File: tb/tb_gpu_data_mem_arbiter.sv
// ============================================================================
// Module  : tb_gpu_data_mem_arbiter
// Purpose : Self-checking bench for gpu_data_mem_arbiter: directed scenarios
//           followed by randomized channel traffic, every cycle compared
//           against a transaction-timeline reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gpu_data_mem_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sram_en, sram_we, busy;
  logic [7:0] sram_addr, sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  gpu_data_mem_arbiter_if #(.NUM_CHANNELS(N), .ADDR_BITS(8), .DATA_BITS(8)) ifc ();

  gpu_data_mem_arbiter #(.NUM_CHANNELS(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ch         (ifc),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .busy       (busy)
  );

  // Synchronous single-port SRAM, 1-cycle read latency
  logic [7:0] sram_mem [256];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata          <= sram_mem[sram_addr];
    end
  end

  // Reference model: timeline of the current transaction
  int         cyc;
  int         gcyc, mg, mptr;
  bit         mop;
  logic [7:0] maddr, mdata;
  bit         rmask [N];
  bit         wmask [N];
  logic [7:0] mm [256];
  bit         e_en, e_we, e_busy;
  logic [7:0] e_addr, e_wdata;
  logic [N-1:0] e_rr, e_wr;
  logic [7:0] e_rdata [N];

  // Channel agents
  bit         r_pend [N];
  bit         w_pend [N];
  bit         r_ling [N];
  bit         w_ling [N];
  bit         r_lreq [N];
  bit         w_lreq [N];
  logic [7:0] r_addr [N];
  logic [7:0] w_addr [N];
  logic [7:0] w_dat  [N];

  typedef struct {int cyc; int ch; bit wr; logic [7:0] data;} ev_t;
  ev_t evq [$];
  int  en_cycs [$];
  logic [7:0] watch_addr;
  int  watch_cnt;

  int n_cmp, n_fail;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    gcyc = -100; mptr = 0; mg = 0; mop = 1'b0; maddr = '0; mdata = '0;
    e_en = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_addr = '0; e_wdata = '0;
    e_rr = '0; e_wr = '0;
    for (int c = 0; c < N; c++) begin
      rmask[c] = 1'b0; wmask[c] = 1'b0; e_rdata[c] = '0;
    end
  endtask

  task automatic agents_clear();
    for (int c = 0; c < N; c++) begin
      r_pend[c] = 0; w_pend[c] = 0; r_ling[c] = 0; w_ling[c] = 0;
      r_lreq[c] = 0; w_lreq[c] = 0; r_addr[c] = '0; w_addr[c] = '0; w_dat[c] = '0;
    end
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      ifc.ch_read_valid[c]    = r_pend[c] | r_ling[c];
      ifc.ch_read_address[c]  = r_addr[c];
      ifc.ch_write_valid[c]   = w_pend[c] | w_ling[c];
      ifc.ch_write_address[c] = w_addr[c];
      ifc.ch_write_data[c]    = w_dat[c];
    end
  endtask

  // Expected outputs after the coming edge, from the inputs it will sample.
  // A transaction granted at edge g: SRAM access at g+1, ready at g+2,
  // next grant no earlier than g+3.
  task automatic model_edge();
    bit set_r, set_w, found;
    int sg, c;
    cyc++;
    e_rr = '0; e_wr = '0;
    set_r = 0; set_w = 0; found = 0; sg = mg;
    if (cyc == gcyc + 1 && mop) mm[maddr] = mdata;
    if (cyc == gcyc + 2) begin
      if (mop) begin e_wr[mg] = 1'b1; set_w = 1; end
      else begin e_rr[mg] = 1'b1; e_rdata[mg] = mm[maddr]; set_r = 1; end
    end
    if (cyc >= gcyc + 3) begin
      for (int k = 0; k < N; k++) begin
        c = (mptr + k) % N;
        if (!found && ((ifc.ch_read_valid[c] && !rmask[c]) ||
                       (ifc.ch_write_valid[c] && !wmask[c]))) begin
          found = 1; mg = c; gcyc = cyc; mptr = (c + 1) % N;
          mop   = ifc.ch_write_valid[c] && !wmask[c];
          maddr = mop ? ifc.ch_write_address[c] : ifc.ch_read_address[c];
          mdata = ifc.ch_write_data[c];
          e_addr = maddr; e_wdata = mdata;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      rmask[k] = rmask[k] & ifc.ch_read_valid[k];
      wmask[k] = wmask[k] & ifc.ch_write_valid[k];
    end
    if (set_r) rmask[sg] = 1'b1;
    if (set_w) wmask[sg] = 1'b1;
    e_en   = (cyc == gcyc);
    e_we   = e_en && mop;
    e_busy = (cyc == gcyc) || (cyc == gcyc + 1);
  endtask

  task automatic check();
    cmp("sram_en", sram_en, e_en);
    cmp("sram_we", sram_we, e_we);
    cmp("sram_addr", sram_addr, e_addr);
    cmp("sram_wdata", sram_wdata, e_wdata);
    cmp("busy", busy, e_busy);
    cmp("read_ready", ifc.ch_read_ready, e_rr);
    cmp("write_ready", ifc.ch_write_ready, e_wr);
    for (int c = 0; c < N; c++)
      cmp($sformatf("read_data[%0d]", c), ifc.ch_read_data[c], e_rdata[c]);
  endtask

  task automatic monitor();
    if (sram_en) begin
      en_cycs.push_back(cyc);
      if (sram_addr == watch_addr) watch_cnt++;
    end
    for (int c = 0; c < N; c++) begin
      if (ifc.ch_read_ready[c])  evq.push_back('{cyc, c, 1'b0, ifc.ch_read_data[c]});
      if (ifc.ch_write_ready[c]) evq.push_back('{cyc, c, 1'b1, 8'h00});
    end
  endtask

  task automatic agents_update();
    for (int c = 0; c < N; c++) begin
      r_ling[c] = 0; w_ling[c] = 0;
      if (ifc.ch_read_ready[c] && r_pend[c])  begin r_pend[c] = 0; r_ling[c] = r_lreq[c]; end
      if (ifc.ch_write_ready[c] && w_pend[c]) begin w_pend[c] = 0; w_ling[c] = w_lreq[c]; end
    end
  endtask

  task automatic cycle();
    drive();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check();
    monitor();
    agents_update();
  endtask

  task automatic post_read(input int c, input logic [7:0] a, input bit linger);
    r_pend[c] = 1; r_addr[c] = a; r_lreq[c] = linger;
  endtask

  task automatic post_write(input int c, input logic [7:0] a, input logic [7:0] d);
    w_pend[c] = 1; w_addr[c] = a; w_dat[c] = d; w_lreq[c] = 0;
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    agents_clear();
    drive();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check();
    evq.delete();
    en_cycs.delete();
  endtask

  task automatic random_posts();
    for (int c = 0; c < N; c++) begin
      if (!r_pend[c] && !r_ling[c] && !ifc.ch_read_valid[c] && $urandom_range(0, 3) == 0)
        post_read(c, 8'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      if (!w_pend[c] && !w_ling[c] && !ifc.ch_write_valid[c] && $urandom_range(0, 4) == 0) begin
        post_write(c, 8'($urandom_range(0, 15)), 8'($urandom));
        w_lreq[c] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  logic [7:0] exp3 [4];
  int t0;

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; watch_addr = 8'h00; watch_cnt = 0;
    exp3[0] = 8'hA5; exp3[1] = 8'hA4; exp3[2] = 8'hA7; exp3[3] = 8'hA6;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = 8'(i) ^ 8'hA5;
      mm[i]       = 8'(i) ^ 8'hA5;
    end
    model_reset();
    hard_reset();
    cmp("reset_busy", busy, 0);
    cmp("reset_sram_en", sram_en, 0);
    cmp("reset_read_ready", ifc.ch_read_ready, 0);

    // Single read ch0 @0x10
    t0 = cyc;
    post_read(0, 8'h10, 0);
    repeat (6) cycle();
    cmp("t1_en_latency", (en_cycs.size() > 0) ? en_cycs[0] - t0 : -1, 1);
    cmp("t1_ready_count", evq.size(), 1);
    if (evq.size() > 0) begin
      cmp("t1_ready_latency", evq[0].cyc - t0, 3);
      cmp("t1_ready_ch", evq[0].ch, 0);
      cmp("t1_data", evq[0].data, 8'hB5);
    end

    // Write ch2 then read the same address on ch1
    evq.delete();
    post_write(2, 8'h20, 8'h5A);
    repeat (5) cycle();
    post_read(1, 8'h20, 0);
    repeat (5) cycle();
    cmp("t2_event_count", evq.size(), 2);
    if (evq.size() == 2) begin
      cmp("t2_write_ch", {evq[0].wr, 8'(evq[0].ch)}, {1'b1, 8'd2});
      cmp("t2_read_ch", {evq[1].wr, 8'(evq[1].ch)}, {1'b0, 8'd1});
      cmp("t2_read_data", evq[1].data, 8'h5A);
    end

    // All four channels read 0..3 together from rr_ptr = 0
    hard_reset();
    for (int c = 0; c < N; c++) post_read(c, 8'(c), 0);
    repeat (15) cycle();
    cmp("t3_event_count", evq.size(), 4);
    if (evq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        cmp($sformatf("t3_order[%0d]", i), evq[i].ch, i);
        cmp($sformatf("t3_data[%0d]", i), evq[i].data, exp3[i]);
        if (i > 0) cmp($sformatf("t3_gap[%0d]", i), evq[i].cyc - evq[i-1].cyc, 3);
      end
    end

    // Ch3 lingers one cycle past its ready
    evq.delete();
    watch_addr = 8'h33; watch_cnt = 0;
    post_read(3, 8'h33, 1);
    repeat (10) cycle();
    cmp("t4_ready_count", evq.size(), 1);
    cmp("t4_sram_accesses", watch_cnt, 1);
    if (evq.size() > 0) cmp("t4_data", evq[0].data, 8'h96);

    // Ch1 read and write together: write first
    evq.delete();
    post_write(1, 8'h40, 8'h11);
    post_read(1, 8'h40, 0);
    repeat (10) cycle();
    cmp("t5_event_count", evq.size(), 2);
    if (evq.size() == 2) begin
      cmp("t5_first_is_write", {evq[0].wr, 8'(evq[0].ch)}, {1'b1, 8'd1});
      cmp("t5_second_is_read", {evq[1].wr, 8'(evq[1].ch)}, {1'b0, 8'd1});
      cmp("t5_read_data", evq[1].data, 8'h11);
    end

    // Reset during the ACCESS phase of a read
    hard_reset();
    post_read(2, 8'h50, 0);
    repeat (4) cycle();
    post_read(0, 8'h60, 0);
    cycle();
    cmp("t6_in_access", sram_en, 1);
    #2 reset = 1'b1;
    #1;
    cmp("t6_rst_sram_en", sram_en, 0);
    cmp("t6_rst_busy", busy, 0);
    cmp("t6_rst_read_data2", ifc.ch_read_data[2], 0);
    cmp("t6_rst_ready", {ifc.ch_read_ready, ifc.ch_write_ready}, 0);
    agents_clear();
    drive();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check();
    evq.delete();
    repeat (3) cycle();
    cmp("t6_no_ready_after_abort", evq.size(), 0);
    post_read(1, 8'h61, 0);
    post_read(3, 8'h63, 0);
    repeat (8) cycle();
    cmp("t6_event_count", evq.size(), 2);
    if (evq.size() == 2) begin
      cmp("t6_first_ch", evq[0].ch, 1);
      cmp("t6_second_ch", evq[1].ch, 3);
    end

    // Randomized traffic
    hard_reset();
    for (int i = 0; i < 3000; i++) begin
      random_posts();
      cycle();
    end
    repeat (20) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
